// File: rtl/bacc_pkg.sv
// bacc_pkg: shared types and constants for the baccarat round controller.
//   state_t          - round sequencer state encoding
//   CARD_W           - width of card values and hand totals (0-9)
//   NATURAL_MIN      - a two-card total at or above this ends the deal (natural)
//   PLAYER_STAND_MIN - a total at or above this stands without a third card
//   STAT_W           - width of the optional round statistics counters
package bacc_pkg;

    localparam int unsigned CARD_W = 4;
    localparam int unsigned STAT_W = 8;

    localparam logic [CARD_W-1:0] NATURAL_MIN      = 4'd8;
    localparam logic [CARD_W-1:0] PLAYER_STAND_MIN = 4'd6;

    typedef enum logic [3:0] {
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_CHK,
        S_P3,
        S_BCHK,
        S_D3,
        S_CMP,
        S_RES
    } state_t;

endpackage

// File: rtl/bacc_banker_rule.sv
// bacc_banker_rule: combinational banker third-card decision, used only after the
// player has drawn a third card.
//   dscore - banker two-card total (0-9)
//   pcard3 - value of the player's third card (0-9)
//   draw   - 1 when the banker must take a third card
module bacc_banker_rule
    import bacc_pkg::*;
(
    input  logic [CARD_W-1:0] dscore,
    input  logic [CARD_W-1:0] pcard3,
    output logic              draw
);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (pcard3 != 4'd8);
            4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
            4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
            4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
            // 7 stands; 8-9 cannot reach here; 10-15 are illegal totals.
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_round_fsm.sv
// baccarat_round_fsm: sequences one baccarat round - deals four cards, applies the
// natural / player / banker third-card rules, latches the result lights and waits
// for the operator to start the next round.
//   slow_clock                 - clock, state changes on rising edge
//   resetb                     - asynchronous active-low reset
//   step                       - one-cycle advance request
//   pscore, dscore             - current hand totals from the scoring stage
//   pcard3                     - player third-card value held in the datapath
//   load_pcard1..3, load_dcard1..3 - hand-register load strobes
//   new_round                  - hand-register clear strobe
//   player_win_light, dealer_win_light - registered result lights (both on = tie)
//   done                       - round complete, result shown
// Optional build macro ROUND_STATS_EN adds saturating counters player_wins,
// dealer_wins and ties, updated when a result is latched.
module baccarat_round_fsm
    import bacc_pkg::*;
(
    input  logic              slow_clock,
    input  logic              resetb,
    input  logic              step,
    input  logic [CARD_W-1:0] pscore,
    input  logic [CARD_W-1:0] dscore,
    input  logic [CARD_W-1:0] pcard3,
    output logic              load_pcard1,
    output logic              load_pcard2,
    output logic              load_pcard3,
    output logic              load_dcard1,
    output logic              load_dcard2,
    output logic              load_dcard3,
    output logic              new_round,
    output logic              player_win_light,
    output logic              dealer_win_light,
    output logic              done
`ifdef ROUND_STATS_EN
    ,
    output logic [STAT_W-1:0] player_wins,
    output logic [STAT_W-1:0] dealer_wins,
    output logic [STAT_W-1:0] ties
`endif
);

    state_t state_q, state_d;
    logic   player_light_d, dealer_light_d;
    logic   banker_draw;

    bacc_banker_rule u_banker_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q          <= S_P1;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else begin
            state_q          <= state_d;
            player_win_light <= player_light_d;
            dealer_win_light <= dealer_light_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        player_light_d = player_win_light;
        dealer_light_d = dealer_win_light;
        load_pcard1    = 1'b0;
        load_pcard2    = 1'b0;
        load_pcard3    = 1'b0;
        load_dcard1    = 1'b0;
        load_dcard2    = 1'b0;
        load_dcard3    = 1'b0;
        new_round      = 1'b0;
        done           = 1'b0;

        case (state_q)
            S_P1: if (step) begin
                load_pcard1 = 1'b1;
                state_d     = S_D1;
            end
            S_D1: if (step) begin
                load_dcard1 = 1'b1;
                state_d     = S_P2;
            end
            S_P2: if (step) begin
                load_pcard2 = 1'b1;
                state_d     = S_D2;
            end
            S_D2: if (step) begin
                load_dcard2 = 1'b1;
                state_d     = S_CHK;
            end
            S_CHK: begin
                if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) begin
                    state_d = S_CMP;
                end else if (pscore < PLAYER_STAND_MIN) begin
                    state_d = S_P3;
                end else if (dscore < PLAYER_STAND_MIN) begin
                    // Player stood, so the banker follows the same 0-5 draw rule.
                    state_d = S_D3;
                end else begin
                    state_d = S_CMP;
                end
            end
            S_P3: if (step) begin
                load_pcard3 = 1'b1;
                state_d     = S_BCHK;
            end
            S_BCHK: state_d = banker_draw ? S_D3 : S_CMP;
            S_D3: if (step) begin
                load_dcard3 = 1'b1;
                state_d     = S_CMP;
            end
            S_CMP: begin
                // Equal totals light both lamps to show a tie.
                player_light_d = (pscore >= dscore);
                dealer_light_d = (dscore >= pscore);
                state_d        = S_RES;
            end
            S_RES: begin
                done = 1'b1;
                if (step) begin
                    new_round      = 1'b1;
                    player_light_d = 1'b0;
                    dealer_light_d = 1'b0;
                    state_d        = S_P1;
                end
            end
            default: state_d = S_P1;
        endcase

        // The state register is already forced to S_P1 during reset; also keep the
        // combinational strobes quiet so a held key cannot load a card.
        if (!resetb) begin
            load_pcard1 = 1'b0;
            load_pcard2 = 1'b0;
            load_pcard3 = 1'b0;
            load_dcard1 = 1'b0;
            load_dcard2 = 1'b0;
            load_dcard3 = 1'b0;
            new_round   = 1'b0;
            done        = 1'b0;
        end
    end

`ifdef ROUND_STATS_EN
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            player_wins <= '0;
            dealer_wins <= '0;
            ties        <= '0;
        end else if (state_q == S_CMP) begin
            if (pscore > dscore) begin
                if (player_wins != '1) player_wins <= player_wins + 1'b1;
            end else if (dscore > pscore) begin
                if (dealer_wins != '1) dealer_wins <= dealer_wins + 1'b1;
            end else begin
                if (ties != '1) ties <= ties + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_baccarat_round_fsm.sv
// tb_baccarat_round_fsm: self-checking bench for baccarat_round_fsm. Each round's
// expected third-card draws and lights are pushed to a scoreboard queue when the
// round's scores are applied and popped when the DUT raises done.
// Build with ROUND_STATS_EN defined to also exercise the statistics counters.
module tb_baccarat_round_fsm;
    import bacc_pkg::*;

    logic       slow_clock = 1'b0;
    logic       resetb;
    logic       step;
    logic [3:0] pscore, dscore, pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       new_round, player_win_light, dealer_win_light, done;
`ifdef ROUND_STATS_EN
    logic [7:0] player_wins, dealer_wins, ties;
`endif

    typedef struct packed {
        logic p_draw;
        logic d_draw;
        logic pl;
        logic dl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 slow_clock = ~slow_clock;

    baccarat_round_fsm dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .step             (step),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .new_round        (new_round),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .done             (done)
`ifdef ROUND_STATS_EN
        ,
        .player_wins      (player_wins),
        .dealer_wins      (dealer_wins),
        .ties             (ties)
`endif
    );

    // Banker draw table: bit n set means the banker draws when the player's third card is n.
    function automatic logic banker_draws(input int ds, input int pc3);
        logic [9:0] mask;
        case (ds)
            0, 1, 2: mask = 10'h3FF;
            3:       mask = 10'h2FF;
            4:       mask = 10'h0FC;
            5:       mask = 10'h0F0;
            6:       mask = 10'h0C0;
            default: mask = 10'h000;
        endcase
        return mask[pc3];
    endfunction

    function automatic exp_t predict(input int ps0, input int ds0, input int pc3,
                                     input int ps1, input int ds1);
        exp_t e;
        int   fp, fd;
        e.p_draw = 1'b0;
        e.d_draw = 1'b0;
        if (!(ps0 >= 8 || ds0 >= 8)) begin
            if (ps0 <= 5) begin
                e.p_draw = 1'b1;
                e.d_draw = banker_draws(ds0, pc3);
            end else begin
                e.d_draw = (ds0 <= 5);
            end
        end
        fp   = e.p_draw ? ps1 : ps0;
        fd   = e.d_draw ? ds1 : ds0;
        e.pl = (fp >= fd);
        e.dl = (fd >= fp);
        return e;
    endfunction

    // Holds step high until done; leaves the DUT in S_RES with step low.
    task automatic play_round(input int ps0, input int ds0, input int pc3,
                              input int ps1, input int ds1, input string name);
        exp_t e;
        int   c_p1 = 0, c_p2 = 0, c_p3 = 0, c_d1 = 0, c_d2 = 0, c_d3 = 0, c_nr = 0;
        logic seen_done = 1'b0;
        logic got_p3, got_d3;
        exp_q.push_back(predict(ps0, ds0, pc3, ps1, ds1));
        pscore = 4'(ps0);
        dscore = 4'(ds0);
        pcard3 = 4'(pc3);
        for (int cyc = 0; cyc < 30 && !seen_done; cyc++) begin
            @(negedge slow_clock);
            step = 1'b1;
            #1;
            if (done) begin
                seen_done = 1'b1;
                step      = 1'b0;
            end else begin
                c_p1 += int'(load_pcard1);
                c_p2 += int'(load_pcard2);
                c_p3 += int'(load_pcard3);
                c_d1 += int'(load_dcard1);
                c_d2 += int'(load_dcard2);
                c_d3 += int'(load_dcard3);
                c_nr += int'(new_round);
                got_p3 = load_pcard3;
                got_d3 = load_dcard3;
                @(posedge slow_clock);
                #1;
                // Model the hand registers: totals change after the third-card load.
                if (got_p3) pscore = 4'(ps1);
                if (got_d3) dscore = 4'(ds1);
            end
        end
        step = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen_done) begin
            n_bad++;
            $display("FAIL %s timeout: done never rose within 30 cycles", name);
        end else begin
            if (c_p1 !== 1 || c_d1 !== 1 || c_p2 !== 1 || c_d2 !== 1) begin
                n_bad++;
                $display("FAIL %s deal strobes: p1=%0d d1=%0d p2=%0d d2=%0d, required 1 each",
                         name, c_p1, c_d1, c_p2, c_d2);
            end
            n_cmp++;
            if (c_p3 !== int'(e.p_draw) || c_d3 !== int'(e.d_draw)) begin
                n_bad++;
                $display("FAIL %s third cards: p3=%0d d3=%0d, required p3=%0d d3=%0d",
                         name, c_p3, c_d3, e.p_draw, e.d_draw);
            end
            n_cmp++;
            if ({player_win_light, dealer_win_light} !== {e.pl, e.dl}) begin
                n_bad++;
                $display("FAIL %s lights: player=%b dealer=%b, required player=%b dealer=%b",
                         name, player_win_light, dealer_win_light, e.pl, e.dl);
            end
            n_cmp++;
            if (c_nr !== 0) begin
                n_bad++;
                $display("FAIL %s new_round during deal: %0d pulses, required 0", name, c_nr);
            end
            // Result must hold while idling in S_RES.
            @(negedge slow_clock);
            #1;
            n_cmp++;
            if ({done, player_win_light, dealer_win_light} !== {1'b1, e.pl, e.dl}) begin
                n_bad++;
                $display("FAIL %s hold: done/pl/dl=%b%b%b, required 1%b%b", name, done,
                         player_win_light, dealer_win_light, e.pl, e.dl);
            end
        end
    endtask

    task automatic end_round(input string name);
        @(negedge slow_clock);
        step = 1'b1;
        #1;
        n_cmp++;
        if (new_round !== 1'b1) begin
            n_bad++;
            $display("FAIL %s new_round: got %b, required 1", name, new_round);
        end
        @(posedge slow_clock);
        #1;
        step = 1'b0;
        n_cmp++;
        if ({done, player_win_light, dealer_win_light} !== 3'b000) begin
            n_bad++;
            $display("FAIL %s after new_round: done/pl/dl=%b%b%b, required 000", name, done,
                     player_win_light, dealer_win_light);
        end
    endtask

    task automatic test_reset();
        logic [6:0] strobes;
        resetb = 1'b0;
        step   = 1'b1;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;
        repeat (3) @(negedge slow_clock);
        #1;
        strobes = {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
                   load_dcard3, new_round};
        n_cmp++;
        if ({strobes, done, player_win_light, dealer_win_light} !== 10'b0) begin
            n_bad++;
            $display("FAIL reset outputs: strobes=%b done=%b pl=%b dl=%b, required all 0",
                     strobes, done, player_win_light, dealer_win_light);
        end
        step   = 1'b0;
        resetb = 1'b1;
        @(negedge slow_clock);
        step = 1'b1;
        #1;
        n_cmp++;
        if (load_pcard1 !== 1'b1 || load_dcard1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset state: load_pcard1=%b load_dcard1=%b, required 1 0",
                     load_pcard1, load_dcard1);
        end
        step = 1'b0;
        #1;
        n_cmp++;
        if (load_pcard1 !== 1'b0) begin
            n_bad++;
            $display("FAIL step gating: load_pcard1=%b with step=0, required 0", load_pcard1);
        end
    endtask

    task automatic test_natural();
        play_round(8, 3, 0, 0, 0, "natural_player");
        end_round("natural_player");
        play_round(2, 9, 0, 0, 0, "natural_dealer");
        end_round("natural_dealer");
    endtask

    task automatic test_both_stand();
        play_round(7, 6, 0, 0, 0, "both_stand");
        end_round("both_stand");
    endtask

    task automatic test_banker_rule();
        play_round(4, 3, 8, 2, 0, "banker3_pc8");
        end_round("banker3_pc8");
        play_round(4, 3, 7, 1, 9, "banker3_pc7");
        end_round("banker3_pc7");
        play_round(6, 4, 0, 0, 7, "player_stands_banker_draws");
        end_round("player_stands_banker_draws");
        play_round(5, 6, 6, 3, 2, "banker6_pc6");
        end_round("banker6_pc6");
        play_round(0, 7, 6, 9, 0, "banker7_stands");
        end_round("banker7_stands");
    endtask

    task automatic test_tie();
        play_round(3, 5, 2, 5, 0, "tie");
        end_round("tie");
    endtask

    task automatic test_reset_mid_round();
        pscore = 4'd4;
        dscore = 4'd3;
        pcard3 = 4'd8;
        repeat (4) begin
            @(negedge slow_clock);
            step = 1'b1;
            @(posedge slow_clock);
            #1;
            step = 1'b0;
        end
        @(posedge slow_clock);  // S_CHK -> S_P3
        @(negedge slow_clock);
        step = 1'b1;
        #1;
        n_cmp++;
        if (load_pcard3 !== 1'b1) begin
            n_bad++;
            $display("FAIL midround reach S_P3: load_pcard3=%b, required 1", load_pcard3);
        end
        #1 resetb = 1'b0;
        #1;
        n_cmp++;
        if (load_pcard3 !== 1'b0 || load_pcard1 !== 1'b0) begin
            n_bad++;
            $display("FAIL midround async reset strobes: p3=%b p1=%b, required 0 0",
                     load_pcard3, load_pcard1);
        end
        step = 1'b0;
        @(negedge slow_clock);
        resetb = 1'b1;
        @(negedge slow_clock);
        step = 1'b1;
        #1;
        n_cmp++;
        if (load_pcard1 !== 1'b1) begin
            n_bad++;
            $display("FAIL midround restart: load_pcard1=%b, required 1", load_pcard1);
        end
        step = 1'b0;
        // Lights must clear asynchronously from S_RES too.
        play_round(9, 1, 0, 0, 0, "lights_before_reset");
        #2 resetb = 1'b0;
        #1;
        n_cmp++;
        if ({done, player_win_light, dealer_win_light} !== 3'b000) begin
            n_bad++;
            $display("FAIL async light clear: done/pl/dl=%b%b%b, required 000", done,
                     player_win_light, dealer_win_light);
        end
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    task automatic test_back_to_back();
        int ps0, ds0, pc3, ps1, ds1;
        for (int r = 0; r < 20; r++) begin
            ps0 = int'($urandom_range(0, 9));
            ds0 = int'($urandom_range(0, 9));
            pc3 = int'($urandom_range(0, 9));
            ps1 = int'($urandom_range(0, 9));
            ds1 = int'($urandom_range(0, 9));
            play_round(ps0, ds0, pc3, ps1, ds1, $sformatf("random%0d", r));
            end_round($sformatf("random%0d", r));
        end
    endtask

`ifdef ROUND_STATS_EN
    task automatic test_stats();
        @(negedge slow_clock);
        resetb = 1'b0;
        @(negedge slow_clock);
        resetb = 1'b1;
        for (int r = 0; r < 256; r++) begin
            play_round(9, 0, 0, 0, 0, "stats");
            end_round("stats");
            if (r == 0) begin
                n_cmp++;
                if (player_wins !== 8'd1) begin
                    n_bad++;
                    $display("FAIL stats first win: player_wins=%0d, required 1", player_wins);
                end
            end
        end
        n_cmp++;
        if (player_wins !== 8'd255 || dealer_wins !== 8'd0 || ties !== 8'd0) begin
            n_bad++;
            $display("FAIL stats saturate: player=%0d dealer=%0d ties=%0d, required 255 0 0",
                     player_wins, dealer_wins, ties);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_natural();
        test_both_stand();
        test_banker_rule();
        test_tie();
        test_reset_mid_round();
        test_back_to_back();
`ifdef ROUND_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/baccarat_round_fsm.md
BACCARAT_ROUND_FSM -- requirements
Module: baccarat_round_fsm

Interface
REQ-001 SHALL have port slow_clock, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port resetb, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port step, input, 1 bit: single-cycle advance request (debounced key pulse).
REQ-004 SHALL have ports pscore and dscore, input, 4 bits each: hand totals 0-9 from the scoring stage, combinational from the hand registers.
REQ-005 SHALL have port pcard3, input, 4 bits: player third-card value 0-9 as registered in the datapath.
REQ-006 SHALL have ports load_pcard1/2/3 and load_dcard1/2/3, output, 1 bit each: datapath hand-register load strobes.
REQ-007 SHALL have port new_round, output, 1 bit: hand-register clear strobe.
REQ-008 SHALL have ports player_win_light and dealer_win_light, output, 1 bit each: result lights.
REQ-009 SHALL have port done, output, 1 bit: round complete.

Function
REQ-010 SHALL implement states S_P1, S_D1, S_P2, S_D2, S_CHK, S_P3, S_BCHK, S_D3, S_CMP, S_RES.
REQ-011 SHALL, in each deal state (S_P1, S_D1, S_P2, S_D2, S_P3, S_D3), assert the matching load strobe combinationally for exactly the cycle where step=1, and advance on that edge; step=0 holds state, all strobes 0.
REQ-012 SHALL sequence S_P1 -> S_D1 -> S_P2 -> S_D2 -> S_CHK.
REQ-013 SHALL leave S_CHK, S_BCHK and S_CMP after one cycle regardless of step; scores sampled there reflect the load of the preceding edge.
REQ-014 SHALL, in S_CHK, go to S_CMP if pscore or dscore is 8 or 9 (natural); else S_P3 if pscore <= 5; else S_D3 if dscore <= 5; else S_CMP.
REQ-015 SHALL, from S_P3 on step, go to S_BCHK.
REQ-016 SHALL, in S_BCHK, go to S_D3 when the banker rule holds, else S_CMP; the rule is: dscore 0-2 always; 3 if pcard3 != 8; 4 if pcard3 in 2..7; 5 if pcard3 in 4..7; 6 if pcard3 in 6..7; 7 never.
REQ-017 SHALL go from S_D3 on step to S_CMP.
REQ-018 SHALL, on the S_CMP -> S_RES edge, register the lights: pscore > dscore gives player=1, dealer=0; dscore > pscore gives player=0, dealer=1; equal gives both 1.
REQ-019 SHALL drive done=1 exactly while in S_RES; lights SHALL hold while in S_RES.
REQ-020 SHALL, in S_RES with step=1, assert new_round for that cycle, clear both lights on the edge, and go to S_P1.
REQ-021 SHALL ignore step in S_CHK, S_BCHK and S_CMP; no strobe SHALL be issued there.
REQ-022 SHALL treat score inputs > 9 as illegal; behaviour SHALL be only that the state stays legal, with no further guarantee.

Reset
REQ-023 SHALL, on resetb=0 at any time including mid-round, force state S_P1 and both lights 0 immediately, without waiting for a clock edge.
REQ-024 SHALL hold all strobes, new_round and done at 0 during reset.

Configuration
REQ-025 SHALL, when ROUND_STATS_EN is defined, add outputs player_wins, dealer_wins and ties, 8 bits each, reset to 0, updated on the S_CMP -> S_RES edge, saturating at 255, and not cleared by new_round.
REQ-026 SHALL, when ROUND_STATS_EN is undefined, omit those ports and counters, leaving behaviour otherwise identical.

Structure
REQ-027 SHALL take the state enum, the score constants (NATURAL_MIN=8, PLAYER_STAND_MIN=6) and the card-value width from shared package bacc_pkg.
REQ-028 SHALL place the REQ-016 banker rule in combinational sub-module bacc_banker_rule (inputs dscore, pcard3; output draw).

Verification
REQ-029 SHALL cover a natural: pscore=8, dscore=3 at S_CHK -> S_CMP, then player_win_light=1, dealer_win_light=0, done=1, with no load_pcard3 or load_dcard3.
REQ-030 SHALL cover both standing: pscore=7, dscore=6 -> no third cards, player_win_light=1.
REQ-031 SHALL cover the banker rule: pscore=4, pcard3=8, dscore=3 -> load_pcard3 issued, then no dealer draw; with pcard3=7 instead -> load_dcard3 issued.
REQ-032 SHALL cover a tie: pscore=dscore=5 at S_CMP -> both lights 1.
REQ-033 SHALL cover reset mid-round: resetb low in S_P3 -> S_P1 and lights 0 asynchronously, and the next step pulses load_pcard1.
REQ-034 SHALL, with ROUND_STATS_EN, play 256 player wins and show player_wins=255 saturated, other counters 0.
